// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the step/clear/load controls and the slave returns the count and its flags.
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             enable;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             ovf;

  modport master (
    output clear, load, load_val, enable, up,
    input  count, at_max, at_min, ovf
  );

  modport slave (
    input  clear, load, load_val, enable, up,
    output count, at_max, at_min, ovf
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down counter with configurable width, modulus and wrap/saturate mode.
// It supports synchronous clear and load, and raises a registered flag on each boundary step.
module mod_updown_counter #(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX      = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  mod_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] load_clamped;
  logic             ovf_q;
  logic             ovf_d;
  logic             boundary;

  // At full-range modulus no load value can exceed MAX, so the clamp compare is dropped.
  generate
    if (MAX == (2**WIDTH) - 1) begin : g_no_clamp
      assign load_clamped = bus.load_val;
    end else begin : g_clamp
      assign load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end
  endgenerate

  assign boundary = bus.enable & (bus.up ? (count_q == MAX_V) : (count_q == '0));

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    count_d = count_q;
    ovf_d   = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = load_clamped;
    end else if (bus.enable) begin
      if (boundary) begin
        ovf_d = 1'b1;
        if (!SATURATE) begin
          count_d = bus.up ? '0 : MAX_V;
        end
      end else begin
        count_d = bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  // NOTE: non-blocking assignments for registered state avoid races between always_ff blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.ovf    = ovf_q;
  assign bus.at_max = (count_q == MAX_V);
  assign bus.at_min = (count_q == '0);

endmodule
